store_port_arbiter: RTL and testbench
=====================================

STORE_PORT_ARBITER -- requirements
Module: store_port_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter NR_PORTS SHALL default to 2 and set the number of store requesters (2..8).
REQ-003 Parameter PLEN SHALL default to 56 and set the physical address width.
REQ-004 Parameter XLEN SHALL default to 64 and set the data width; byte-enable width is XLEN/8.
REQ-005 Port list, one per line:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  NR_PORTS  per-port write request
- urgent_i  in  NR_PORTS  per-port high-priority flag, sampled only with req_i
- addr_i  in  NR_PORTS*PLEN  per-port physical address (port k at slice k)
- data_i  in  NR_PORTS*XLEN  per-port write data
- be_i  in  NR_PORTS*XLEN/8  per-port byte enables
- size_i  in  NR_PORTS*2  per-port transfer size
- gnt_o  out  NR_PORTS  one-hot grant pulse back to the winning requester
- req_o  out  1  write request to D$
- addr_o  out  PLEN  registered address to D$
- data_o  out  XLEN  registered data to D$
- be_o  out  XLEN/8  registered byte enables to D$
- size_o  out  2  registered size to D$
- gnt_i  in  1  D$ accepts the current request
- busy_o  out  1  high while a request is outstanding to D$
- idx_o  out  clog2(NR_PORTS)  index of the port owning the outstanding request

Function
REQ-006 States SHALL be IDLE and WAIT_GNT; req_o = busy_o = (state == WAIT_GNT).
REQ-007 Eligible set SHALL be req_i masked by ~onehot(idx_q) when in WAIT_GNT with gnt_i=1, otherwise req_i unmasked.
REQ-008 If any eligible port has urgent_i=1, arbitration SHALL consider only urgent eligible ports; otherwise all eligible ports.
REQ-009 Winner SHALL be the first considered port at or after rr_q, searching upward with wrap from NR_PORTS-1 to 0.
REQ-010 In IDLE with ≥1 eligible port: capture winner payload into output registers, idx_q <= winner, go to WAIT_GNT; gnt_o stays 0.
REQ-011 In IDLE with no eligible port: remain in IDLE; output registers unchanged.
REQ-012 In WAIT_GNT: addr_o/data_o/be_o/size_o/idx_o SHALL stay constant until the cycle in which gnt_i=1.
REQ-013 In WAIT_GNT with gnt_i=1: gnt_o[idx_q]=1 combinationally in that cycle; rr_q <= (idx_q+1) mod NR_PORTS.
REQ-014 Same cycle as REQ-013: if ≥1 eligible port, load its payload and stay in WAIT_GNT (back-to-back, no bubble); else go to IDLE.
REQ-015 Requesters SHALL hold req_i and payload stable until gnt_o; a requester dropping req_i while owner does not cancel the in-flight request.
REQ-016 gnt_o SHALL be zero except in a WAIT_GNT cycle with gnt_i=1, and never more than one bit high.
REQ-017 gnt_i in IDLE SHALL be ignored.
REQ-018 Minimum latency req_i-to-req_o SHALL be 1 cycle; throughput SHALL be one grant per cycle with gnt_i held high and ≥2 active ports.
REQ-019 Non-urgent ports MAY starve while urgent requests persist; this is intended.

Reset
REQ-020 On rst_i=1 at a clock edge: state <= IDLE, rr_q <= 0, idx_q <= 0, addr_o/data_o/be_o/size_o <= 0; gnt_o=0, req_o=0, busy_o=0 from the next cycle.
REQ-021 Reset during WAIT_GNT SHALL abandon the outstanding request without issuing gnt_o.

Verification
REQ-022 Single port: req_i=2'b01, addr=0x1000, gnt_i=1 one cycle after req_o -> req_o high cycle 1, addr_o=0x1000, gnt_o=2'b01 in the gnt_i cycle, IDLE afterward.
REQ-023 Round robin: req_i=2'b11 held, gnt_i=1 constant -> grants alternate 01,10,01,10 with no idle cycle between grants.
REQ-024 Urgent override: req_i=2'b11, urgent_i=2'b10, rr_q=0 -> port 1 wins; after grant with urgent cleared, port 0 wins next.
REQ-025 Backpressure: gnt_i=0 for 5 cycles while other ports toggle payload -> addr_o/data_o/idx_o unchanged, gnt_o=0 throughout.
REQ-026 Reset mid-request: rst_i=1 during WAIT_GNT with gnt_i=1 -> no gnt_o pulse, req_o=0 next cycle, next arbitration starts from port 0.

Source files
------------

// File: rtl/store_port_arbiter.sv
// rtl/store_port_arbiter.sv - round-robin store port arbiter with urgent override toward the D$ write port
module store_port_arbiter #(
    parameter int NR_PORTS = 2,
    parameter int PLEN     = 56,
    parameter int XLEN     = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR_PORTS-1:0]        req_i,
    input  logic [NR_PORTS-1:0]        urgent_i,
    input  logic [NR_PORTS*PLEN-1:0]   addr_i,
    input  logic [NR_PORTS*XLEN-1:0]   data_i,
    input  logic [NR_PORTS*XLEN/8-1:0] be_i,
    input  logic [NR_PORTS*2-1:0]      size_i,
    output logic [NR_PORTS-1:0]        gnt_o,
    output logic                       req_o,
    output logic [PLEN-1:0]            addr_o,
    output logic [XLEN-1:0]            data_o,
    output logic [XLEN/8-1:0]          be_o,
    output logic [1:0]                 size_o,
    input  logic                       gnt_i,
    output logic                       busy_o,
    output logic [$clog2(NR_PORTS)-1:0] idx_o
);

    localparam int BEW   = XLEN / 8;
    localparam int IDX_W = $clog2(NR_PORTS);

    typedef enum logic {IDLE, WAIT_GNT} state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      rr_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  granting;
    logic [NR_PORTS-1:0]   owner_oh;
    logic [NR_PORTS-1:0]   eligible;
    logic [NR_PORTS-1:0]   urgent_elig;
    logic [NR_PORTS-1:0]   consider;
    logic                  found;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      rr_next;
    logic [PLEN-1:0]       addr_sel;
    logic [XLEN-1:0]       data_sel;
    logic [BEW-1:0]        be_sel;
    logic [1:0]            size_sel;

    assign granting    = (state_q == WAIT_GNT) && gnt_i;
    assign owner_oh    = {{(NR_PORTS-1){1'b0}}, 1'b1} << idx_q;
    // The owner being granted this cycle must not immediately win again.
    assign eligible    = req_i & ~(granting ? owner_oh : {NR_PORTS{1'b0}});
    assign urgent_elig = eligible & urgent_i;
    assign consider    = (|urgent_elig) ? urgent_elig : eligible;
    assign rr_next     = (idx_q == IDX_W'(NR_PORTS - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            int               cand;
            logic [IDX_W-1:0] cand_idx;
            cand = int'(rr_q) + i;
            if (cand >= NR_PORTS) begin
                cand = cand - NR_PORTS;
            end
            cand_idx = IDX_W'(cand);
            if (!found && consider[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        be_sel   = '0;
        size_sel = '0;
        for (int k = 0; k < NR_PORTS; k++) begin
            if (winner == IDX_W'(k)) begin
                addr_sel = addr_i[k*PLEN +: PLEN];
                data_sel = data_i[k*XLEN +: XLEN];
                be_sel   = be_i[k*BEW +: BEW];
                size_sel = size_i[k*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            addr_o  <= '0;
            data_o  <= '0;
            be_o    <= '0;
            size_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        addr_o  <= addr_sel;
                        data_o  <= data_sel;
                        be_o    <= be_sel;
                        size_o  <= size_sel;
                        idx_q   <= winner;
                        state_q <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (gnt_i) begin
                        rr_q <= rr_next;
                        if (found) begin
                            addr_o <= addr_sel;
                            data_o <= data_sel;
                            be_o   <= be_sel;
                            size_o <= size_sel;
                            idx_q  <= winner;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset in the same cycle as gnt_i abandons the request, so no pulse escapes.
    assign gnt_o  = (granting && !rst_i) ? owner_oh : {NR_PORTS{1'b0}};
    assign req_o  = (state_q == WAIT_GNT);
    assign busy_o = (state_q == WAIT_GNT);
    assign idx_o  = idx_q;

endmodule

// File: tb/tb_store_port_arbiter.sv
// tb/tb_store_port_arbiter.sv - scoreboard bench for store_port_arbiter
module tb_store_port_arbiter;

    localparam int NR   = 2;
    localparam int PLEN = 56;
    localparam int XLEN = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR-1:0]     urgent = '0;
    logic [NR*PLEN-1:0] addr = '0;
    logic [NR*XLEN-1:0] data = '0;
    logic [NR*8-1:0]   be = '0;
    logic [NR*2-1:0]   size = '0;
    logic [NR-1:0]     gnt_o;
    logic              req_o;
    logic [PLEN-1:0]   addr_o;
    logic [XLEN-1:0]   data_o;
    logic [7:0]        be_o;
    logic [1:0]        size_o;
    logic              gnt_i = 1'b0;
    logic              busy_o;
    logic [0:0]        idx_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [55:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t q[$];

    store_port_arbiter #(.NR_PORTS(NR), .PLEN(PLEN), .XLEN(XLEN)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .urgent_i(urgent),
        .addr_i(addr), .data_i(data), .be_i(be), .size_i(size),
        .gnt_o(gnt_o), .req_o(req_o), .addr_o(addr_o), .data_o(data_o),
        .be_o(be_o), .size_o(size_o), .gnt_i(gnt_i), .busy_o(busy_o),
        .idx_o(idx_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] port_be(int k);
        return (k == 0) ? 8'h0F : 8'hF0;
    endfunction

    function automatic logic [1:0] port_size(int k);
        return (k == 0) ? 2'b11 : 2'b10;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int k, logic [55:0] a, logic [63:0] d);
        addr[k*PLEN +: PLEN] = a;
        data[k*XLEN +: XLEN] = d;
        be[k*8 +: 8]         = port_be(k);
        size[k*2 +: 2]       = port_size(k);
    endtask

    task automatic expect_grant(int k, logic [55:0] a, logic [63:0] d);
        exp_t e;
        e.port = k;
        e.addr = a;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        urgent = '0;
        gnt_i  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: every grant pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (gnt_o !== '0) begin
            if (q.size() == 0) begin
                check("unexpected_gnt", 64'(gnt_o), 64'h0);
            end else begin
                exp_t e;
                logic [NR-1:0] oh;
                e  = q.pop_front();
                oh = '0;
                oh[e.port] = 1'b1;
                check("gnt_onehot", 64'(gnt_o), 64'(oh));
                check("gnt_idx", 64'(idx_o), 64'(e.port));
                check("gnt_addr", 64'(addr_o), 64'(e.addr));
                check("gnt_data", data_o, e.data);
                check("gnt_be", 64'(be_o), 64'(port_be(e.port)));
                check("gnt_size", 64'(size_o), 64'(port_size(e.port)));
            end
        end
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_req_o", 64'(req_o), 64'h0);
        check("rst_busy_o", 64'(busy_o), 64'h0);
        check("rst_gnt_o", 64'(gnt_o), 64'h0);
        check("rst_addr_o", 64'(addr_o), 64'h0);
        check("rst_data_o", data_o, 64'h0);
        check("rst_idx_o", 64'(idx_o), 64'h0);
        rst = 1'b0;

        // Single port request
        set_port(0, 56'h1000, 64'h1111_2222_3333_4444);
        req = 2'b01;
        expect_grant(0, 56'h1000, 64'h1111_2222_3333_4444);
        tick();
        check("single_req_latency", 64'(req_o), 64'h1);
        check("single_addr_o", 64'(addr_o), 64'h1000);
        gnt_i = 1'b1;
        tick();
        req   = '0;
        gnt_i = 1'b0;
        check("single_idle_after", 64'(req_o), 64'h0);
        tick();

        // Round robin, back-to-back grants
        do_reset();
        set_port(0, 56'hA0, 64'hAAAA_0000_0000_00A0);
        set_port(1, 56'hB1, 64'hBBBB_0000_0000_00B1);
        req   = 2'b11;
        gnt_i = 1'b1;
        expect_grant(0, 56'hA0, 64'hAAAA_0000_0000_00A0);
        expect_grant(1, 56'hB1, 64'hBBBB_0000_0000_00B1);
        expect_grant(0, 56'hA0, 64'hAAAA_0000_0000_00A0);
        expect_grant(1, 56'hB1, 64'hBBBB_0000_0000_00B1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_busy_no_bubble", 64'(busy_o), 64'h1);
        end
        req = '0;
        tick();
        check("rr_idle_after", 64'(busy_o), 64'h0);
        gnt_i = 1'b0;

        // Urgent override
        do_reset();
        req    = 2'b11;
        urgent = 2'b10;
        expect_grant(1, 56'hB1, 64'hBBBB_0000_0000_00B1);
        expect_grant(0, 56'hA0, 64'hAAAA_0000_0000_00A0);
        tick();
        check("urgent_winner", 64'(idx_o), 64'h1);
        urgent = '0;
        gnt_i  = 1'b1;
        tick();
        check("urgent_next_port0", 64'(idx_o), 64'h0);
        req = 2'b01;
        tick();
        req   = '0;
        gnt_i = 1'b0;
        check("urgent_idle_after", 64'(busy_o), 64'h0);

        // Backpressure while the other port churns
        do_reset();
        set_port(0, 56'h2222, 64'hDEAD_BEEF_0000_0001);
        req = 2'b01;
        expect_grant(0, 56'h2222, 64'hDEAD_BEEF_0000_0001);
        tick();
        for (int i = 0; i < 5; i++) begin
            req[1]    = i[0];
            urgent[1] = i[0];
            set_port(1, 56'h3000 + 56'(i), 64'(i) * 64'h0101);
            tick();
            check("bp_addr_hold", 64'(addr_o), 64'h2222);
            check("bp_data_hold", data_o, 64'hDEAD_BEEF_0000_0001);
            check("bp_idx_hold", 64'(idx_o), 64'h0);
            check("bp_gnt_zero", 64'(gnt_o), 64'h0);
        end
        req    = 2'b01;
        urgent = '0;
        gnt_i  = 1'b1;
        tick();
        req   = '0;
        gnt_i = 1'b0;
        check("bp_idle_after", 64'(busy_o), 64'h0);

        // Reset during an outstanding request
        do_reset();
        set_port(0, 56'h4000, 64'h4444_0000_0000_4000);
        set_port(1, 56'h5001, 64'h5555_0000_0000_5001);
        req   = 2'b01;
        gnt_i = 1'b1;
        expect_grant(0, 56'h4000, 64'h4444_0000_0000_4000);
        tick();
        tick();
        req   = 2'b11;
        gnt_i = 1'b0;
        tick();
        check("rst_pre_owner", 64'(idx_o), 64'h1);
        gnt_i = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        check("rst_no_gnt", 64'(gnt_o), 64'h0);
        tick();
        rst = 1'b0;
        check("rst_req_drop", 64'(req_o), 64'h0);
        check("rst_idx_cleared", 64'(idx_o), 64'h0);
        check("rst_addr_cleared", 64'(addr_o), 64'h0);
        expect_grant(0, 56'h4000, 64'h4444_0000_0000_4000);
        tick();
        check("rst_rr_from_port0", 64'(idx_o), 64'h0);
        req = 2'b01;
        tick();
        req   = '0;
        gnt_i = 1'b0;
        check("rst_idle_after", 64'(busy_o), 64'h0);
        tick();
        tick();

        check("all_grants_seen", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
